// File: rtl/cpu_defs.sv
// Shared definitions for the interrupt dispatch slice: FSM state encoding,
// default vector table placement and priority-index width.
package cpu_defs;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    WAIT,
    PUSH_HI,
    PUSH_LO,
    JUMP
  } irq_state_t;

  localparam logic [15:0] DEF_VEC_BASE   = 16'h0040;
  localparam int unsigned DEF_VEC_STRIDE = 8;
  localparam int unsigned IDX_W          = 3;

endpackage

// File: rtl/irq_dispatch_if.sv
// Stack-push memory handshake between the dispatcher and the memory system.
interface irq_dispatch_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack);
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest-numbered asserted request wins.
module irq_prio_enc
  import cpu_defs::*;
#(
  parameter int unsigned NUM_IRQ = 5
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (req[i] && !valid) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: IME handling, HALT wake-up, and the vectored dispatch
// sequence (wait, push PC high/low onto the stack, jump to the vector).
module irq_dispatch
  import cpu_defs::*;
#(
  parameter int unsigned NUM_IRQ    = 5,
  parameter logic [15:0] VEC_BASE   = DEF_VEC_BASE,
  parameter int unsigned VEC_STRIDE = DEF_VEC_STRIDE,
  parameter int unsigned WAIT_CLKS  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_flags,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic               instr_boundary,
  input  logic               ei_strobe,
  input  logic               di_strobe,
  input  logic               reti_strobe,
  input  logic               halt_req,
  input  logic [15:0]        pc_in,
  input  logic [15:0]        sp_in,
  irq_dispatch_if.master     mem,
  output logic               pc_load,
  output logic               sp_load,
  output logic [15:0]        pc_value,
  output logic [15:0]        sp_value,
  output logic [NUM_IRQ-1:0] if_clear,
  output logic               ime,
  output logic               halted,
  output logic               busy,
  output logic               irq_pending
);

  localparam int unsigned     CNT_W    = (WAIT_CLKS > 1) ? $clog2(WAIT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CLKS - 1);
  localparam logic [15:0]     STRIDE16 = 16'(VEC_STRIDE);

  irq_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic               ei_pend;
  logic               ei_step;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;
  logic [NUM_IRQ-1:0] pending;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_valid;

  assign pending     = irq_flags & irq_enable;
  assign irq_pending = |pending;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req   (pending),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      ei_pend       <= 1'b0;
      ei_step       <= 1'b0;
      win_idx       <= '0;
      win_valid     <= 1'b0;
      ime           <= 1'b0;
      halted        <= 1'b0;
      busy          <= 1'b0;
      pc_load       <= 1'b0;
      sp_load       <= 1'b0;
      pc_value      <= '0;
      sp_value      <= '0;
      if_clear      <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      pc_load  <= 1'b0;
      sp_load  <= 1'b0;
      if_clear <= '0;

      // EI takes effect on the second instruction boundary after it is seen
      if (di_strobe) begin
        ime     <= 1'b0;
        ei_pend <= 1'b0;
        ei_step <= 1'b0;
      end else if (!busy) begin
        if (reti_strobe)
          ime <= 1'b1;
        if (ei_strobe) begin
          ei_pend <= 1'b1;
          ei_step <= 1'b0;
        end else if (ei_pend && instr_boundary) begin
          if (ei_step) begin
            ime     <= 1'b1;
            ei_pend <= 1'b0;
          end else begin
            ei_step <= 1'b1;
          end
        end
      end

      // FSM writes to ime come last so dispatch entry overrides a same-cycle set
      case (state)
        IDLE: begin
          if (instr_boundary && ime && irq_pending) begin
            state <= WAIT;
            ime   <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
          end else if (halt_req && !irq_pending) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          if (irq_pending) begin
            halted <= 1'b0;
            if (ime) begin
              state <= WAIT;
              ime   <= 1'b0;
              busy  <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            state         <= PUSH_HI;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= 1'b1;
            mem.mem_addr  <= sp_in - 16'd1;
            mem.mem_wdata <= pc_in[15:8];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PUSH_HI: begin
          if (mem.mem_ack) begin
            state         <= PUSH_LO;
            mem.mem_addr  <= sp_in - 16'd2;
            mem.mem_wdata <= pc_in[7:0];
            win_idx       <= enc_idx;
            win_valid     <= enc_valid;
          end
        end
        PUSH_LO: begin
          if (mem.mem_ack) begin
            state       <= JUMP;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            pc_load     <= 1'b1;
            sp_load     <= 1'b1;
            sp_value    <= sp_in - 16'd2;
            pc_value    <= win_valid ? VEC_BASE + 16'(win_idx) * STRIDE16 : '0;
            if_clear    <= win_valid ? NUM_IRQ'(1) << win_idx : '0;
          end
        end
        JUMP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_dispatch.sv
// Directed bench for irq_dispatch: dispatch sequence, priority, EI/DI timing,
// HALT wake-up, cancelled dispatch and reset during a push.
module tb_irq_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  irq_flags = '0;
  logic [4:0]  irq_enable = '0;
  logic        instr_boundary = 1'b0;
  logic        ei_strobe = 1'b0;
  logic        di_strobe = 1'b0;
  logic        reti_strobe = 1'b0;
  logic        halt_req = 1'b0;
  logic [15:0] pc_in = '0;
  logic [15:0] sp_in = '0;
  logic        pc_load, sp_load;
  logic [15:0] pc_value, sp_value;
  logic [4:0]  if_clear;
  logic        ime, halted, busy, irq_pending;
  logic        ack_auto = 1'b1;
  logic        ack_man = 1'b0;

  int total = 0;
  int bad = 0;

  irq_dispatch_if bus ();
  assign bus.mem_ack = ack_auto ? bus.mem_req : ack_man;

  irq_dispatch dut (
    .clk            (clk),
    .rst            (rst),
    .irq_flags      (irq_flags),
    .irq_enable     (irq_enable),
    .instr_boundary (instr_boundary),
    .ei_strobe      (ei_strobe),
    .di_strobe      (di_strobe),
    .reti_strobe    (reti_strobe),
    .halt_req       (halt_req),
    .pc_in          (pc_in),
    .sp_in          (sp_in),
    .mem            (bus),
    .pc_load        (pc_load),
    .sp_load        (sp_load),
    .pc_value       (pc_value),
    .sp_value       (sp_value),
    .if_clear       (if_clear),
    .ime            (ime),
    .halted         (halted),
    .busy           (busy),
    .irq_pending    (irq_pending)
  );

  always #5 clk = ~clk;

  logic [15:0] wr_addr [16];
  logic [7:0]  wr_data [16];
  int          wr_cnt = 0;
  int          pl_cnt = 0;
  int          mreq_cnt = 0;
  logic [15:0] cap_pc, cap_sp;
  logic [4:0]  cap_ifc;

  always @(negedge clk) begin
    if (bus.mem_req) mreq_cnt++;
    if (bus.mem_req && bus.mem_ack && bus.mem_we && wr_cnt < 16) begin
      wr_addr[wr_cnt] = bus.mem_addr;
      wr_data[wr_cnt] = bus.mem_wdata;
      wr_cnt++;
    end
    if (pc_load) begin
      pl_cnt++;
      cap_pc  = pc_value;
      cap_sp  = sp_value;
      cap_ifc = if_clear;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_pl(input int n0);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (pl_cnt != n0) break;
    end
    check("pc_load_seen", pl_cnt, n0 + 1);
  endtask

  initial begin
    int w0, p0, m0;

    // reset state
    tick(); tick();
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_ime", ime, 1'b0);
    check("rst_pc_value", pc_value, 16'h0000);
    rst = 1'b0;
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_if_clear", if_clear, 5'b0);
    check("rst_mem_addr", bus.mem_addr, 16'h0000);

    // basic dispatch: source 2
    reti_strobe = 1'b1; tick(); reti_strobe = 1'b0;
    check("reti_ime", ime, 1'b1);
    irq_enable = 5'h1F; irq_flags = 5'b00100;
    pc_in = 16'h1234; sp_in = 16'hFFFE;
    #1 check("irq_pending", irq_pending, 1'b1);
    w0 = wr_cnt; p0 = pl_cnt;
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    check("disp_busy", busy, 1'b1);
    check("disp_ime_clr", ime, 1'b0);
    wait_pl(p0);
    check("wr0_addr", wr_addr[w0], 16'hFFFD);
    check("wr0_data", wr_data[w0], 8'h12);
    check("wr1_addr", wr_addr[w0 + 1], 16'hFFFC);
    check("wr1_data", wr_data[w0 + 1], 8'h34);
    check("vec2_pc", cap_pc, 16'h0050);
    check("vec2_sp", cap_sp, 16'hFFFC);
    check("vec2_ifc", cap_ifc, 5'b00100);
    check("disp_busy_end", busy, 1'b0);
    irq_flags = '0;

    // priority: bits 1 and 2 pending, bit 1 wins
    reti_strobe = 1'b1; tick(); reti_strobe = 1'b0;
    irq_flags = 5'b00110;
    w0 = wr_cnt; p0 = pl_cnt;
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    wait_pl(p0);
    check("vec1_pc", cap_pc, 16'h0048);
    check("vec1_ifc", cap_ifc, 5'b00010);
    check("vec1_writes", wr_cnt - w0, 2);
    irq_flags = '0;

    // EI delay and DI cancel
    ei_strobe = 1'b1; tick(); ei_strobe = 1'b0;
    check("ei_armed", ime, 1'b0);
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    check("ei_bnd1", ime, 1'b0);
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    check("ei_bnd2", ime, 1'b1);
    di_strobe = 1'b1; tick(); di_strobe = 1'b0;
    check("di_clr", ime, 1'b0);
    ei_strobe = 1'b1; tick(); ei_strobe = 1'b0;
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    di_strobe = 1'b1; tick(); di_strobe = 1'b0;
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    check("ei_di_bnd2", ime, 1'b0);
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    check("ei_di_bnd3", ime, 1'b0);
    ei_strobe = 1'b1; di_strobe = 1'b1; tick(); ei_strobe = 1'b0; di_strobe = 1'b0;
    instr_boundary = 1'b1; tick(); tick(); instr_boundary = 1'b0;
    check("di_beats_ei", ime, 1'b0);

    // HALT with ime=0, woken by IF bit 0
    m0 = mreq_cnt; p0 = pl_cnt;
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    check("halt_enter", halted, 1'b1);
    tick();
    check("halt_stay", halted, 1'b1);
    irq_flags = 5'b00001;
    tick();
    check("halt_exit", halted, 1'b0);
    check("halt_exit_busy", busy, 1'b0);
    tick(); tick();
    check("halt_no_mreq", mreq_cnt - m0, 0);
    check("halt_no_pl", pl_cnt - p0, 0);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    check("halt_blocked", halted, 1'b0);
    irq_flags = '0;

    // cancelled dispatch with delayed ack
    reti_strobe = 1'b1; tick(); reti_strobe = 1'b0;
    ack_auto = 1'b0; ack_man = 1'b0;
    irq_flags = 5'b00100; pc_in = 16'h1234; sp_in = 16'hFFFE;
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    m0 = mreq_cnt;
    repeat (7) tick();
    check("wait_len_lo", bus.mem_req, 1'b0);
    tick();
    check("push_hi_req", bus.mem_req, 1'b1);
    check("push_hi_addr", bus.mem_addr, 16'hFFFD);
    irq_flags = '0;
    tick(); tick();
    check("push_hi_hold", bus.mem_req, 1'b1);
    tick();
    ack_man = 1'b1;
    check("push_hi_hold4", bus.mem_req, 1'b1);
    tick();
    check("push_hi_cycles", mreq_cnt - m0, 4);
    check("push_lo_addr", bus.mem_addr, 16'hFFFC);
    check("push_lo_data", bus.mem_wdata, 8'h34);
    tick();
    ack_man = 1'b0;
    check("cancel_pl", pc_load, 1'b1);
    check("cancel_pc", pc_value, 16'h0000);
    check("cancel_ifc", if_clear, 5'b0);
    check("cancel_mreq", bus.mem_req, 1'b0);
    tick();
    check("cancel_busy", busy, 1'b0);

    // SP wrap at 0x0001
    ack_auto = 1'b1;
    reti_strobe = 1'b1; tick(); reti_strobe = 1'b0;
    irq_flags = 5'b00001; pc_in = 16'hABCD; sp_in = 16'h0001;
    w0 = wr_cnt; p0 = pl_cnt;
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    wait_pl(p0);
    check("wrap_addr_hi", wr_addr[w0], 16'h0000);
    check("wrap_data_hi", wr_data[w0], 8'hAB);
    check("wrap_addr_lo", wr_addr[w0 + 1], 16'hFFFF);
    check("wrap_data_lo", wr_data[w0 + 1], 8'hCD);
    check("wrap_sp", cap_sp, 16'hFFFF);
    check("vec0_pc", cap_pc, 16'h0040);
    check("vec0_ifc", cap_ifc, 5'b00001);
    irq_flags = '0;

    // reset during PUSH_LO
    reti_strobe = 1'b1; tick(); reti_strobe = 1'b0;
    ack_auto = 1'b0; ack_man = 1'b0;
    irq_flags = 5'b00001; pc_in = 16'h1234; sp_in = 16'hFFFE;
    p0 = pl_cnt;
    instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.mem_req) break;
      tick();
    end
    check("rstp_req_seen", bus.mem_req, 1'b1);
    ack_man = 1'b1; tick(); ack_man = 1'b0;
    check("rstp_lo_addr", bus.mem_addr, 16'hFFFC);
    #2 rst = 1'b1;
    #1;
    check("rstp_mreq", bus.mem_req, 1'b0);
    check("rstp_ime", ime, 1'b0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rstp_no_pl", pl_cnt - p0, 0);
    check("rstp_busy", busy, 1'b0);
    irq_flags = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
